bcd_counter_2digit: RTL and testbench

Two-digit BCD up/down counter that generates the digit codes consumed by the seven-segment decoders on the board. A programmable prescaler turns the system clock into count ticks. Each tick steps a 00–99 BCD value, and the two 4-bit digits drive two decoder instances directly. The block supports clear, parallel load, direction control and a terminal-count pulse for cascading.

---
 rtl/bcd_counter_2digit.sv | 103 ++++++++++
 tb/tb_bcd_counter_2digit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter (00-99) stepped by a programmable prescaler.
// Provides clear, saturating parallel load, direction control and a wrap pulse.
module bcd_counter_2digit #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tc
);

  localparam int unsigned      PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    LP_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic          r_tc;

  logic          w_tick;
  logic          w_wrap;
  logic [PW-1:0] w_presc_nxt;
  logic [3:0]    w_ones_nxt;
  logic [3:0]    w_tens_nxt;
  logic [3:0]    w_ld_ones;
  logic [3:0]    w_ld_tens;

  always_comb begin
    w_tick      = en & (r_presc == LP_LAST);
    w_presc_nxt = (r_presc == LP_LAST) ? '0 : r_presc + PW'(1);
    w_ones_nxt  = r_ones;
    w_tens_nxt  = r_tens;
    w_wrap      = 1'b0;
    w_ld_ones   = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
    w_ld_tens   = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
    if (up) begin
      if (r_ones == 4'd9) begin
        w_ones_nxt = '0;
        if (r_tens == 4'd9) begin
          w_tens_nxt = '0;
          w_wrap     = 1'b1;
        end else begin
          w_tens_nxt = r_tens + 4'd1;
        end
      end else begin
        w_ones_nxt = r_ones + 4'd1;
      end
    end else begin
      if (r_ones == 4'd0) begin
        w_ones_nxt = 4'd9;
        if (r_tens == 4'd0) begin
          w_tens_nxt = 4'd9;
          w_wrap     = 1'b1;
        end else begin
          w_tens_nxt = r_tens - 4'd1;
        end
      end else begin
        w_ones_nxt = r_ones - 4'd1;
      end
    end
  end

  // Prescaler holds (not clears) while en is low, so a pending tick survives a pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_ones  <= '0;
      r_tens  <= '0;
      r_tc    <= 1'b0;
    end else if (clr) begin
      r_presc <= '0;
      r_ones  <= '0;
      r_tens  <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_presc <= '0;
      r_ones  <= w_ld_ones;
      r_tens  <= w_ld_tens;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (en) begin
        r_presc <= w_presc_nxt;
      end
      if (w_tick) begin
        r_ones <= w_ones_nxt;
        r_tens <= w_tens_nxt;
        r_tc   <= w_wrap;
      end
    end
  end

  assign ones = r_ones;
  assign tens = r_tens;
  assign tc   = r_tc;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Directed self-checking bench: three instances with TICK_DIV of 4, 1 and 5
// share clock and reset; each is driven by its own control inputs.
module tb_bcd_counter_2digit;

  logic clk;
  logic rst_n;

  logic       en4, up4, clr4, load4;
  logic [7:0] lv4;
  logic [3:0] ones4, tens4;
  logic       tc4;

  logic       en1, up1, clr1, load1;
  logic [7:0] lv1;
  logic [3:0] ones1, tens1;
  logic       tc1;

  logic       en5, up5, clr5, load5;
  logic [7:0] lv5;
  logic [3:0] ones5, tens5;
  logic       tc5;

  int unsigned n_checks;
  int unsigned n_errors;

  bcd_counter_2digit #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .up(up4), .clr(clr4), .load(load4),
    .load_val(lv4), .ones(ones4), .tens(tens4), .tc(tc4)
  );

  bcd_counter_2digit #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .up(up1), .clr(clr1), .load(load1),
    .load_val(lv1), .ones(ones1), .tens(tens1), .tc(tc1)
  );

  bcd_counter_2digit #(.TICK_DIV(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .up(up5), .clr(clr5), .load(load5),
    .load_val(lv5), .ones(ones5), .tens(tens5), .tc(tc5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] o, input logic [3:0] t,
                           input logic c, input int unsigned v, input logic exp_tc);
    check({tag, ".ones"}, 32'(o), 32'(v % 10));
    check({tag, ".tens"}, 32'(t), 32'(v / 10));
    check({tag, ".tc"},   32'(c), 32'(exp_tc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    {en4, up4, clr4, load4} = 4'b0100; lv4 = '0;
    {en1, up1, clr1, load1} = 4'b0100; lv1 = '0;
    {en5, up5, clr5, load5} = 4'b0100; lv5 = '0;

    // Reset state
    step(); step();
    check_cnt("rst4", ones4, tens4, tc4, 0, 1'b0);
    check_cnt("rst1", ones1, tens1, tc1, 0, 1'b0);

    // Count up from reset release, TICK_DIV=4: step on every 4th edge
    en4 = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_cnt($sformatf("up4_e%0d", k), ones4, tens4, tc4, k / 4, 1'b0);
    end
    en4 = 1'b0;

    // Up wrap, TICK_DIV=1
    load1 = 1'b1; lv1 = 8'h98;
    step();
    check_cnt("ld98", ones1, tens1, tc1, 98, 1'b0);
    load1 = 1'b0; en1 = 1'b1; up1 = 1'b1;
    step(); check_cnt("upw_99", ones1, tens1, tc1, 99, 1'b0);
    step(); check_cnt("upw_00", ones1, tens1, tc1, 0, 1'b1);
    step(); check_cnt("upw_01", ones1, tens1, tc1, 1, 1'b0);
    en1 = 1'b0;

    // Down wrap
    load1 = 1'b1; lv1 = 8'h01;
    step(); check_cnt("ld01", ones1, tens1, tc1, 1, 1'b0);
    load1 = 1'b0; en1 = 1'b1; up1 = 1'b0;
    step(); check_cnt("dnw_00", ones1, tens1, tc1, 0, 1'b0);
    step(); check_cnt("dnw_99", ones1, tens1, tc1, 99, 1'b1);
    step(); check_cnt("dnw_98", ones1, tens1, tc1, 98, 1'b0);
    en1 = 1'b0;

    // Load saturation
    load1 = 1'b1; lv1 = 8'hC7;
    step(); check_cnt("ldC7", ones1, tens1, tc1, 97, 1'b0);
    lv1 = 8'hA3;
    step(); check_cnt("ldA3", ones1, tens1, tc1, 93, 1'b0);
    lv1 = 8'hFF;
    step(); check_cnt("ldFF", ones1, tens1, tc1, 99, 1'b0);
    // load wins over tick, then clr wins over load, then clr alone
    lv1 = 8'h42; en1 = 1'b1; up1 = 1'b1;
    step(); check_cnt("ld_tick", ones1, tens1, tc1, 42, 1'b0);
    load1 = 1'b0;
    step(); check_cnt("after_ld_tick", ones1, tens1, tc1, 43, 1'b0);
    clr1 = 1'b1; load1 = 1'b1; lv1 = 8'h55;
    step(); check_cnt("clr_ld", ones1, tens1, tc1, 0, 1'b0);
    load1 = 1'b0; lv1 = 8'h37;
    load1 = 1'b1; clr1 = 1'b0;
    step(); check_cnt("ld37", ones1, tens1, tc1, 37, 1'b0);
    load1 = 1'b0; clr1 = 1'b1; en1 = 1'b0;
    step(); check_cnt("clr_en0", ones1, tens1, tc1, 0, 1'b0);
    clr1 = 1'b0;

    // Enable gating, TICK_DIV=5: pause of 3 edges delays step by 3;
    // pause while prescaler sits at its last value defers the step.
    clr5 = 1'b1;
    step();
    clr5 = 1'b0; en5 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      en5 = ((k >= 8 && k <= 10) || k == 18 || k == 19) ? 1'b0 : 1'b1;
      step();
      check_cnt($sformatf("gate5_e%0d", k), ones5, tens5, tc5,
                (k < 5) ? 0 : (k < 13) ? 1 : (k < 20) ? 2 : 3, 1'b0);
    end
    en5 = 1'b0;

    // Async reset mid-count at 57
    load4 = 1'b1; lv4 = 8'h57;
    step(); check_cnt("ld57", ones4, tens4, tc4, 57, 1'b0);
    load4 = 1'b0; en4 = 1'b1;
    step(); step();
    check_cnt("pre_rst57", ones4, tens4, tc4, 57, 1'b0);
    #3 rst_n = 1'b0;
    #1 check_cnt("async_rst", ones4, tens4, tc4, 0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_cnt($sformatf("resume_e%0d", k), ones4, tens4, tc4, k / 4, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
